// File: rtl/store_data_align_pkg.sv
// Shared definitions for the store data alignment path: funct3 codes,
// FSM state encoding and byte-mask helpers.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } st_state_e;

  // Byte-lane mask before shifting; illegal codes give an empty mask.
  function automatic logic [3:0] mask_of(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   mask_of = 4'b0001;
      F3_SH:   mask_of = 4'b0011;
      F3_SW:   mask_of = 4'b1111;
      default: mask_of = 4'b0000;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] funct3);
    f3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane placement: shifts store data and byte enables into a
// two-word window so that a misaligned store spills into the upper word.
module store_lane_shift
  import store_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [1:0]         off,
  input  logic [2:0]         funct3,
  output logic [2*WIDTH-1:0] data64,
  output logic [7:0]         be8,
  output logic               split,
  output logic               illegal
);

  // Shift data by whole bytes and the mask by lanes; split when the upper word is touched.
  always_comb begin
    data64  = {{WIDTH{1'b0}}, data} << {off, 3'b000};
    be8     = {4'b0000, mask_of(funct3)} << off;
    split   = |be8[7:4];
    illegal = !f3_legal(funct3);
  end

endmodule

// File: rtl/store_data_align.sv
// Store alignment unit: captures one store, emits one or two word-aligned
// write beats with byte enables, then pulses completion.
module store_data_align
  import store_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0]      st_data,
  output logic                  st_done,
  output logic                  st_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt
);

  st_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]      data_reg;
  logic [2:0]            funct3_reg;

  logic [2*WIDTH-1:0]    data64;
  logic [7:0]            be8;
  logic                  split;
  logic                  illegal;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_addr;

  assign accept    = st_valid && (state_reg == IDLE);
  assign base_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};

  store_lane_shift #(.WIDTH(WIDTH)) u_lane_shift (
    .data    (data_reg),
    .off     (addr_reg[1:0]),
    .funct3  (funct3_reg),
    .data64  (data64),
    .be8     (be8),
    .split   (split),
    .illegal (illegal)
  );

  // State register and request capture; capture only happens on an accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      data_reg   <= '0;
      funct3_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= st_addr;
        data_reg   <= st_data;
        funct3_reg <= st_funct3;
      end
    end
  end

  // Next-state selection; beats advance only on a memory handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = f3_legal(st_funct3) ? BEAT0 : FIN;
      BEAT0: if (mem_gnt) state_next = split ? BEAT1 : FIN;
      BEAT1: if (mem_gnt) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat payload driven from captured registers so it holds across stalls; zero when idle.
  always_comb begin
    st_ready  = (state_reg == IDLE);
    st_done   = (state_reg == FIN);
    st_err    = (state_reg == FIN) && illegal;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (state_reg == BEAT0) begin
      mem_req   = 1'b1;
      mem_addr  = base_addr;
      mem_wdata = data64[WIDTH-1:0];
      mem_be    = be8[3:0];
    end else if (state_reg == BEAT1) begin
      mem_req   = 1'b1;
      mem_addr  = base_addr + ADDR_WIDTH'(4);
      mem_wdata = data64[2*WIDTH-1:WIDTH];
      mem_be    = be8[7:4];
    end
  end

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
Store-side counterpart of the load data extraction path. It accepts one RISC-V store (SB/SH/SW) per request from the execute stage and places the rs2 data into the correct byte lanes of a 32-bit word-addressed data memory, with byte enables. Misaligned SH/SW stores that cross a word boundary are split into two word-aligned write beats. It sits between the execute stage and the data-memory write port.

Parameters:
WIDTH, 32, data and word width in bits; only 32 is supported.
ADDR_WIDTH, 32, byte address width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
st_valid  input  1  store request valid.
st_ready  output  1  unit can accept a request; high only in IDLE.
st_funct3  input  3  store funct3: 000=SB, 001=SH, 010=SW.
st_addr  input  ADDR_WIDTH  byte address.
st_data  input  WIDTH  rs2 value; low bytes are used.
st_done  output  1  one-cycle pulse when the store is finished.
st_err  output  1  one-cycle pulse, together with st_done, for an illegal funct3.
mem_req  output  1  write beat valid.
mem_addr  output  ADDR_WIDTH  word-aligned beat address; bits [1:0] are always 00.
mem_wdata  output  WIDTH  lane-aligned write data.
mem_be  output  4  byte enables; bit i enables byte lane i.
mem_gnt  input  1  memory accepts the beat.

Behaviour:
- Accept: the request is captured on an edge where st_valid && st_ready.
  - Capture addr, funct3 and data into registers.
  - Inputs are ignored at all other times.
- Byte mask by funct3: SB=0001, SH=0011, SW=1111.
- Lane shift: with off = addr[1:0],
  - data64 = {32'b0, data} << (8*off)
  - be8 = {4'b0, mask} << off
- Beat 0: addr = {addr[A-1:2], 2'b00}, wdata = data64[31:0], be = be8[3:0].
- Beat 1: issued only if be8[7:4] != 0.
  - addr = beat0 addr + 4, wrapping modulo 2^ADDR_WIDTH.
  - wdata = data64[63:32], be = be8[7:4].
- FSM states: IDLE, BEAT0, BEAT1, FIN.
  - IDLE -> BEAT0 on a legal accept.
  - IDLE -> FIN on an accept with funct3 not in {000, 001, 010}; no memory traffic is generated.
  - BEAT0 -> BEAT1 on a handshake when a second beat is needed; otherwise BEAT0 -> FIN on the handshake.
  - BEAT1 -> FIN on a handshake.
  - FIN -> IDLE unconditionally.
- Handshake:
  - mem_req is high in BEAT0/BEAT1 only.
  - A beat transfers on an edge where mem_req && mem_gnt.
  - While mem_req=1 and mem_gnt=0, mem_addr, mem_wdata and mem_be stay stable.
  - mem_gnt while mem_req=0 is ignored.
- st_done = (state==FIN). st_err = (state==FIN && captured funct3 illegal).
- st_ready = (state==IDLE). There is no back-to-back accept while FIN is active.
- Latency: accept on edge N, mem_req high in cycle N+1. With mem_gnt tied high:
  - aligned store: st_done in cycle N+2, st_ready in cycle N+3.
  - split store: one extra cycle.
  - illegal funct3: st_done/st_err in cycle N+1.
- Reset (rst_n=0 on an edge): state returns to IDLE from any state, including mid-beat.
  - mem_req, st_done and st_err are 0 from the next cycle.
  - mem_addr, mem_wdata and mem_be are 0; captured registers are 0.
  - An in-flight store is dropped without a completion pulse.
- Outputs while idle: mem_addr, mem_wdata and mem_be are 0 whenever mem_req=0.

Decomposition:
- Package store_pkg:
  - funct3 constants F3_SB, F3_SH, F3_SW.
  - state enum st_state_e {IDLE, BEAT0, BEAT1, FIN}.
  - Byte-mask function mask_of(funct3).
- Sub-module store_lane_shift: purely combinational.
  - Inputs: data, off, funct3.
  - Outputs: data64, be8, split flag, illegal flag.
  - The top module holds the FSM and registers.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, gnt=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; st_done in cycle N+2.
- SB, addr 0x103, data 0x123456A5 -> one beat: addr 0x100, be 1000, wdata 0xA5000000.
- SH, addr 0x203, data 0x00001234 -> two beats:
  - 0x200 / be 1000 / 0x34000000
  - 0x204 / be 0001 / 0x00000012
  - then one st_done.
- SW, addr 0x102, data 0x11223344, gnt low 3 cycles per beat -> two beats:
  - 0x100 / be 1100 / 0x33440000
  - 0x104 / be 0011 / 0x00001122
  - payload stable while stalled; st_ready low throughout.
- SW, addr 0xFFFFFFFE, data 0xAABBCCDD -> two beats:
  - 0xFFFFFFFC / be 1100 / 0xCCDD0000
  - 0x00000000 / be 0011 / 0x0000AABB
- Illegal funct3=011 -> no mem_req; st_done=st_err=1 for one cycle.
- Reset mid-op: rst_n=0 during a stalled BEAT1 -> next cycle mem_req=0, st_ready=1, no st_done.
